// File: rtl/apb_master_arbiter_pkg.sv
// apb_master_arbiter_pkg: shared FSM encoding and requester indices for the
// two-requester APB master arbiter.
package apb_master_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;
   localparam logic REQ_M0 = 1'b0;
   localparam logic REQ_M1 = 1'b1;
endpackage

// File: rtl/apb_master_arbiter_rr.sv
// apb_rr_arbiter2: two-way round-robin pick; on a tie the requester not
// served last wins. Output is only meaningful when some req bit is set.
module apb_rr_arbiter2
   import apb_master_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);
   always_comb grant = (&req) ? ~last : (req[1] ? REQ_M1 : REQ_M0);
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between two requesters with
// round-robin arbitration and an optional ACCESS-phase timeout.
module apb_master_arbiter
   import apb_master_arbiter_pkg::*;
#(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 32,
   parameter int TIMEOUT   = 16
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 PCLKEN,
   input  logic                 m0_psel,
   input  logic                 m1_psel,
   input  logic [ADDRWIDTH-1:0] m0_paddr,
   input  logic [ADDRWIDTH-1:0] m1_paddr,
   input  logic                 m0_pwrite,
   input  logic                 m1_pwrite,
   input  logic [DATAWIDTH-1:0] m0_pwdata,
   input  logic [DATAWIDTH-1:0] m1_pwdata,
   output logic                 m0_pready,
   output logic                 m1_pready,
   output logic [DATAWIDTH-1:0] m0_prdata,
   output logic [DATAWIDTH-1:0] m1_prdata,
   output logic                 m0_pslverr,
   output logic                 m1_pslverr,
   output logic                 PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [ADDRWIDTH-1:0] PADDR,
   output logic [DATAWIDTH-1:0] PWDATA,
   input  logic [DATAWIDTH-1:0] PRDATA,
   input  logic                 PREADY,
   input  logic                 PSLVERR,
   output logic                 APBACTIVE
);
   // A zero-width counter is illegal, so a disabled timeout keeps one dummy bit.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   apb_state_e    state, next_state;
   logic          grant, arb_grant, timeout_hit, done;
   logic [CW-1:0] count;

   apb_rr_arbiter2 u_arb (.req({m1_psel, m0_psel}), .last(grant), .grant(arb_grant));

   assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST) && !PREADY;
   assign done        = (state == ACCESS) && PCLKEN && (PREADY || timeout_hit);

   always_comb begin
      next_state = state;
      if (PCLKEN)
         unique case (state)
            IDLE:    next_state = (m0_psel || m1_psel) ? SETUP : IDLE;
            SETUP:   next_state = ACCESS;
            ACCESS:  next_state = done ? IDLE : ACCESS;
            default: next_state = IDLE;
         endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) state <= IDLE;
      else          state <= next_state;

   // grant doubles as the last-served index once the transfer finishes.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         grant   <= REQ_M1;
         count   <= '0;
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PADDR   <= '0;
         PWDATA  <= '0;
      end else if (PCLKEN) begin
         if (state == IDLE && (m0_psel || m1_psel)) begin
            grant   <= arb_grant;
            PADDR   <= arb_grant ? m1_paddr : m0_paddr;
            PWRITE  <= arb_grant ? m1_pwrite : m0_pwrite;
            PWDATA  <= arb_grant ? m1_pwdata : m0_pwdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            count   <= '0;
         end else if (state == SETUP) begin
            PENABLE <= 1'b1;
         end else if (state == ACCESS) begin
            if (done) begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end else if (count != '1) begin
               count <= count + CW'(1);
            end
         end
      end
   end

   assign m0_pready  = done && (grant == REQ_M0);
   assign m1_pready  = done && (grant == REQ_M1);
   assign m0_prdata  = (grant == REQ_M0) ? PRDATA : '0;
   assign m1_prdata  = (grant == REQ_M1) ? PRDATA : '0;
   assign m0_pslverr = m0_pready && (PSLVERR || timeout_hit);
   assign m1_pslverr = m1_pready && (PSLVERR || timeout_hit);
   assign APBACTIVE  = (state != IDLE) || m0_psel || m1_psel;
endmodule
